// File: rtl/xgmii_pattern_gen_chk.sv
// Framed XGMII traffic generator plus incrementing-payload frame checker.
// Latency: TX start word one cycle after i_enable is sampled; RX stats one cycle after the FD word.
// Backpressure: none; the generator free-runs on the XGMII clock and the checker accepts every word.
module xgmii_pattern_gen_chk #(
    parameter int P_CNT_W     = 32,
    parameter int P_IFG_WORDS = 2,
    parameter int P_LANE0_MSB = 1,
    parameter int P_LEN_MIN   = 8
) (
    input  logic               i_xgmii_clk,
    input  logic               i_xgmii_rst_n,
    input  logic               i_enable,
    input  logic [15:0]        i_frame_len,
    input  logic [15:0]        i_frame_num,
    input  logic               i_clr_stats,
    output logic [63:0]        o_xgmii_txd,
    output logic [7:0]         o_xgmii_txc,
    input  logic [63:0]        i_xgmii_rxd,
    input  logic [7:0]         i_xgmii_rxc,
    output logic               o_busy,
    output logic [P_CNT_W-1:0] o_tx_frame_cnt,
    output logic [P_CNT_W-1:0] o_rx_frame_cnt,
    output logic [P_CNT_W-1:0] o_rx_err_cnt,
    output logic               o_rx_byte_err
);

    localparam logic [7:0] C_IDLE  = 8'h07;
    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;
    // Start word in lane order (lane i at bits [8i+:8]): FB, six 55, D5.
    localparam logic [63:0] C_START_LV = {8'hD5, {6{8'h55}}, C_START};

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_PAYLOAD, TX_TERM, TX_IFG} tx_state_t;
    typedef enum logic [1:0] {RX_HUNT, RX_PRE, RX_DATA} rx_state_t;

    // Lane-order <-> bus mapping; byte reversal is its own inverse, so TX and RX share it.
    function automatic logic [63:0] f_map_dat(input logic [63:0] v);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (P_LANE0_MSB != 0) r[8*(7-i) +: 8] = v[8*i +: 8];
            else                  r[8*i +: 8]     = v[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] f_map_ctl(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (P_LANE0_MSB != 0) r[7-i] = v[i];
            else                  r[i]   = v[i];
        end
        return r;
    endfunction

    // Payload word with rem bytes still to send: full word when rem >= 8, otherwise
    // rem data lanes, FD in lane rem and idles above it (rem == 0 is the plain TERM word).
    function automatic logic [63:0] f_pay_dat(input logic [15:0] rem, input logic [7:0] base);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (16'(i) < rem)       r[8*i +: 8] = base + 8'(i);
            else if (16'(i) == rem) r[8*i +: 8] = C_TERM;
            else                    r[8*i +: 8] = C_IDLE;
        end
        return r;
    endfunction

    function automatic logic [7:0] f_pay_ctl(input logic [15:0] rem);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = (16'(i) >= rem);
        return r;
    endfunction

    function automatic logic [P_CNT_W-1:0] f_sat_inc(input logic [P_CNT_W-1:0] v);
        return (&v) ? v : v + P_CNT_W'(1);
    endfunction

    logic [15:0] w_len_clamp;
    assign w_len_clamp = (i_frame_len < 16'(P_LEN_MIN)) ? 16'(P_LEN_MIN) : i_frame_len;

    // ---------------- TX generator ----------------
    tx_state_t   r_tx_state, w_tx_state_nxt;
    logic [15:0] r_rem, w_rem_nxt;       // payload bytes not yet placed on the bus
    logic [7:0]  r_boff, w_boff_nxt;     // offset of next payload byte within the frame
    logic [7:0]  r_seq, w_seq_nxt;       // frame index since reset, seeds payload
    logic [15:0] r_sent, w_sent_nxt;     // frames terminated in this burst
    logic [3:0]  r_ifg, w_ifg_nxt;       // idle words still owed after the terminate
    logic [63:0] w_tx_lv;
    logic [7:0]  w_tx_lc;
    logic        w_tx_fd;
    logic        w_more;

    logic [63:0] r_txd;
    logic [7:0]  r_txc;

    assign w_more = i_enable && ((i_frame_num == 16'd0) || (r_sent < i_frame_num));

    // TX next state and the word to register; the output is loaded with the word of the next state.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_rem_nxt      = r_rem;
        w_boff_nxt     = r_boff;
        w_seq_nxt      = r_seq;
        w_sent_nxt     = r_sent;
        w_ifg_nxt      = r_ifg;
        w_tx_lv        = {8{C_IDLE}};
        w_tx_lc        = 8'hFF;
        w_tx_fd        = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (i_enable) begin
                    w_tx_state_nxt = TX_START;
                    w_rem_nxt      = w_len_clamp;
                    w_boff_nxt     = 8'd0;
                    w_sent_nxt     = 16'd0;
                    w_tx_lv        = C_START_LV;
                    w_tx_lc        = 8'h01;
                end
            end
            TX_START, TX_PAYLOAD: begin
                w_tx_lv = f_pay_dat(r_rem, r_seq + r_boff);
                w_tx_lc = f_pay_ctl(r_rem);
                if (r_rem >= 16'd8) begin
                    w_rem_nxt      = r_rem - 16'd8;
                    w_boff_nxt     = r_boff + 8'd8;
                    w_tx_state_nxt = TX_PAYLOAD;
                end else begin
                    w_tx_fd    = 1'b1;
                    w_sent_nxt = r_sent + 16'd1;
                    w_seq_nxt  = r_seq + 8'd1;
                    if (r_rem == 16'd0) begin
                        w_tx_state_nxt = TX_TERM;
                    end else begin
                        w_tx_state_nxt = TX_IFG;
                        w_ifg_nxt      = 4'(P_IFG_WORDS);
                    end
                end
            end
            TX_TERM: begin
                w_tx_state_nxt = TX_IFG;
                w_ifg_nxt      = 4'(P_IFG_WORDS - 1);
            end
            TX_IFG: begin
                if (r_ifg != 4'd0) begin
                    w_ifg_nxt = r_ifg - 4'd1;
                end else if (w_more) begin
                    w_tx_state_nxt = TX_START;
                    w_rem_nxt      = w_len_clamp;
                    w_boff_nxt     = 8'd0;
                    w_tx_lv        = C_START_LV;
                    w_tx_lc        = 8'h01;
                end else begin
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    // TX state and output word registers.
    always_ff @(posedge i_xgmii_clk or negedge i_xgmii_rst_n) begin
        if (!i_xgmii_rst_n) begin
            r_tx_state <= TX_IDLE;
            r_rem      <= '0;
            r_boff     <= '0;
            r_seq      <= '0;
            r_sent     <= '0;
            r_ifg      <= '0;
            r_txd      <= {8{C_IDLE}};
            r_txc      <= 8'hFF;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_rem      <= w_rem_nxt;
            r_boff     <= w_boff_nxt;
            r_seq      <= w_seq_nxt;
            r_sent     <= w_sent_nxt;
            r_ifg      <= w_ifg_nxt;
            r_txd      <= f_map_dat(w_tx_lv);
            r_txc      <= f_map_ctl(w_tx_lc);
        end
    end

    // ---------------- RX checker ----------------
    rx_state_t   r_rx_state, w_rx_st;
    logic [7:0]  r_rx_exp, w_rx_exp;     // next expected payload byte
    logic [15:0] r_rx_len, w_rx_len;     // payload bytes received so far
    logic [15:0] r_rx_elen, w_rx_elen;   // expected length latched at frame start
    logic        r_rx_bad, w_rx_bad;
    logic        w_rx_done, w_rx_done_bad, w_rx_stop;
    logic [63:0] w_rd;
    logic [7:0]  w_rc;
    logic        w_is_start, w_pre_ok;

    assign w_rd       = f_map_dat(i_xgmii_rxd);
    assign w_rc       = f_map_ctl(i_xgmii_rxc);
    assign w_is_start = (w_rc == 8'h01) && (w_rd[7:0] == C_START);
    assign w_pre_ok   = (w_rd[63:8] == C_START_LV[63:8]);

    // Walk the received word lane by lane: seed/compare data, stop at the first control byte.
    always_comb begin
        w_rx_st       = r_rx_state;
        w_rx_exp      = r_rx_exp;
        w_rx_len      = r_rx_len;
        w_rx_elen     = r_rx_elen;
        w_rx_bad      = r_rx_bad;
        w_rx_done     = 1'b0;
        w_rx_done_bad = 1'b0;
        w_rx_stop     = 1'b0;
        if (w_is_start) begin
            // A start inside a frame closes the old one as bad and opens a new one.
            if (r_rx_state != RX_HUNT) begin
                w_rx_done     = 1'b1;
                w_rx_done_bad = 1'b1;
            end
            w_rx_st   = RX_PRE;
            w_rx_bad  = !w_pre_ok;
            w_rx_len  = 16'd0;
            w_rx_elen = w_len_clamp;
        end else if (r_rx_state != RX_HUNT) begin
            for (int i = 0; i < 8; i++) begin
                if (!w_rx_stop) begin
                    if (w_rc[i]) begin
                        w_rx_stop = 1'b1;
                        w_rx_done = 1'b1;
                        w_rx_st   = RX_HUNT;
                        if (w_rd[8*i +: 8] == C_TERM)
                            w_rx_done_bad = w_rx_bad || (w_rx_len != w_rx_elen);
                        else
                            w_rx_done_bad = 1'b1;
                    end else begin
                        if (w_rx_st == RX_PRE) begin
                            w_rx_st = RX_DATA;
                        end else if (w_rd[8*i +: 8] != w_rx_exp) begin
                            w_rx_bad = 1'b1;
                        end
                        w_rx_exp = (w_rx_st == RX_DATA && w_rx_len != 16'd0) ?
                                   w_rx_exp + 8'd1 : w_rd[8*i +: 8] + 8'd1;
                        if (w_rx_len != 16'hFFFF) w_rx_len = w_rx_len + 16'd1;
                    end
                end
            end
        end
    end

    // RX framing state registers.
    always_ff @(posedge i_xgmii_clk or negedge i_xgmii_rst_n) begin
        if (!i_xgmii_rst_n) begin
            r_rx_state    <= RX_HUNT;
            r_rx_exp      <= '0;
            r_rx_len      <= '0;
            r_rx_elen     <= '0;
            r_rx_bad      <= 1'b0;
            o_rx_byte_err <= 1'b0;
        end else begin
            r_rx_state    <= w_rx_st;
            r_rx_exp      <= w_rx_exp;
            r_rx_len      <= w_rx_len;
            r_rx_elen     <= w_rx_elen;
            r_rx_bad      <= w_rx_bad;
            o_rx_byte_err <= w_rx_done && w_rx_done_bad;
        end
    end

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge i_xgmii_clk or negedge i_xgmii_rst_n) begin
        if (!i_xgmii_rst_n) begin
            o_tx_frame_cnt <= '0;
            o_rx_frame_cnt <= '0;
            o_rx_err_cnt   <= '0;
        end else if (i_clr_stats) begin
            o_tx_frame_cnt <= '0;
            o_rx_frame_cnt <= '0;
            o_rx_err_cnt   <= '0;
        end else begin
            if (w_tx_fd)                   o_tx_frame_cnt <= f_sat_inc(o_tx_frame_cnt);
            if (w_rx_done)                 o_rx_frame_cnt <= f_sat_inc(o_rx_frame_cnt);
            if (w_rx_done && w_rx_done_bad) o_rx_err_cnt  <= f_sat_inc(o_rx_err_cnt);
        end
    end

    assign o_xgmii_txd = r_txd;
    assign o_xgmii_txc = r_txc;
    assign o_busy      = (r_tx_state != TX_IDLE);

endmodule

// File: tb/tb_xgmii_pattern_gen_chk.sv
module tb_xgmii_pattern_gen_chk;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] TERM_W = 64'hFD07070707070707;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] len = 16'd0;
    logic [15:0] num = 16'd0;
    logic        clr = 1'b0;

    // DUT0: default parameters, looped back with an optional bit flip.
    logic        rst0_n = 1'b0, en0 = 1'b0;
    logic [63:0] txd0, flip0 = 64'h0;
    logic [7:0]  txc0;
    logic        busy0, perr0;
    logic [31:0] txcnt0, rxcnt0, errcnt0;

    // DUT1: 8-bit counters for saturation.
    logic        rst1_n = 1'b0, en1 = 1'b0;
    logic [63:0] txd1;
    logic [7:0]  txc1;
    logic        busy1, perr1;
    logic [7:0]  txcnt1, rxcnt1, errcnt1;

    // DUT2: lane 0 in the low byte.
    logic        rst2_n = 1'b0, en2 = 1'b0;
    logic [63:0] txd2;
    logic [7:0]  txc2;
    logic        busy2, perr2;
    logic [31:0] txcnt2, rxcnt2, errcnt2;

    xgmii_pattern_gen_chk u_dut0 (
        .i_xgmii_clk(clk), .i_xgmii_rst_n(rst0_n), .i_enable(en0),
        .i_frame_len(len), .i_frame_num(num), .i_clr_stats(clr),
        .o_xgmii_txd(txd0), .o_xgmii_txc(txc0),
        .i_xgmii_rxd(txd0 ^ flip0), .i_xgmii_rxc(txc0),
        .o_busy(busy0), .o_tx_frame_cnt(txcnt0), .o_rx_frame_cnt(rxcnt0),
        .o_rx_err_cnt(errcnt0), .o_rx_byte_err(perr0));

    xgmii_pattern_gen_chk #(.P_CNT_W(8)) u_dut1 (
        .i_xgmii_clk(clk), .i_xgmii_rst_n(rst1_n), .i_enable(en1),
        .i_frame_len(len), .i_frame_num(num), .i_clr_stats(clr),
        .o_xgmii_txd(txd1), .o_xgmii_txc(txc1),
        .i_xgmii_rxd(txd1), .i_xgmii_rxc(txc1),
        .o_busy(busy1), .o_tx_frame_cnt(txcnt1), .o_rx_frame_cnt(rxcnt1),
        .o_rx_err_cnt(errcnt1), .o_rx_byte_err(perr1));

    xgmii_pattern_gen_chk #(.P_LANE0_MSB(0)) u_dut2 (
        .i_xgmii_clk(clk), .i_xgmii_rst_n(rst2_n), .i_enable(en2),
        .i_frame_len(len), .i_frame_num(num), .i_clr_stats(clr),
        .o_xgmii_txd(txd2), .o_xgmii_txc(txc2),
        .i_xgmii_rxd(txd2), .i_xgmii_rxc(txc2),
        .o_busy(busy2), .o_tx_frame_cnt(txcnt2), .o_rx_frame_cnt(rxcnt2),
        .o_rx_err_cnt(errcnt2), .o_rx_byte_err(perr2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e;
        int          n, pulses;
        logic        seen_term, seen3, flipped, prev_start, done;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_txd", txd0, IDLE_W);
        chk("rst_txc", txc0, 8'hFF);
        chk("rst_busy", busy0, 0);
        chk("rst_cnts", {txcnt0, rxcnt0 | errcnt0}, 64'h0);
        chk("rst_perr", perr0, 0);
        rst0_n = 1'b1; rst1_n = 1'b1; rst2_n = 1'b1;
        @(negedge clk);

        // ---- T1: single 64-byte frame ----
        len = 16'd64; num = 16'd1; en0 = 1'b1;
        @(negedge clk);
        en0 = 1'b0;
        chk("t1_start_txd", txd0, 64'hFB555555555555D5);
        chk("t1_start_txc", txc0, 8'h80);
        chk("t1_busy", busy0, 1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) e[63-8*k -: 8] = 8'(8*j + k);
            chk($sformatf("t1_pay%0d", j), {txc0, txd0[55:0]}, {8'h00, e[55:0]});
            chk($sformatf("t1_payhi%0d", j), txd0[63:56], e[63:56]);
        end
        @(negedge clk);
        chk("t1_term", {txc0, txd0}, {8'hFF, TERM_W});
        chk("t1_txcnt", txcnt0, 1);
        @(negedge clk);
        chk("t1_ifg1", {busy0, txc0, txd0}, {1'b1, 8'hFF, IDLE_W});
        @(negedge clk);
        chk("t1_ifg2", {busy0, txc0, txd0}, {1'b1, 8'hFF, IDLE_W});
        @(negedge clk);
        chk("t1_idle", {busy0, txc0, txd0}, {1'b0, 8'hFF, IDLE_W});
        chk("t1_rx", {rxcnt0, errcnt0}, {32'd1, 32'd0});

        // ---- T2: loopback, len 61, 100 frames ----
        rst0_n = 1'b0; @(negedge clk); rst0_n = 1'b1;
        len = 16'd61; num = 16'd100; en0 = 1'b1;
        seen_term = 0; seen3 = 0; prev_start = 0; done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (txc0 == 8'h07 && !seen_term) begin
                chk("t2_term_word", txd0, 64'h38393A3B3CFD0707);
                seen_term = 1;
            end
            if (prev_start && txcnt0 == 3 && !seen3) begin
                chk("t2_frame3_byte0", txd0[63:56], 8'h03);
                seen3 = 1;
            end
            prev_start = (txc0 == 8'h80) && (txd0[63:56] == 8'hFB);
            if (!busy0) done = 1;
        end
        en0 = 1'b0;
        chk("t2_finished", done, 1);
        chk("t2_seen", {seen_term, seen3}, 2'b11);
        chk("t2_txcnt", txcnt0, 100);
        chk("t2_rxcnt", rxcnt0, 100);
        chk("t2_errcnt", errcnt0, 0);

        // ---- T3: bit flip in frame 5 ----
        rst0_n = 1'b0; @(negedge clk); rst0_n = 1'b1;
        len = 16'd61; num = 16'd10; en0 = 1'b1;
        flipped = 0; pulses = 0; done = 0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (perr0) pulses++;
            if (!flipped && txcnt0 == 5 && txc0 == 8'h00) begin
                flip0 = 64'h1; flipped = 1;
            end else begin
                flip0 = 64'h0;
            end
            if (!busy0) done = 1;
        end
        en0 = 1'b0; flip0 = 64'h0;
        chk("t3_finished", done, 1);
        chk("t3_errcnt", errcnt0, 1);
        chk("t3_pulses", pulses, 1);
        chk("t3_rxcnt", rxcnt0, 10);

        // ---- T4: length clamped to minimum ----
        rst0_n = 1'b0; @(negedge clk); rst0_n = 1'b1;
        len = 16'd4; num = 16'd3; en0 = 1'b1;
        @(negedge clk);
        chk("t4_start", {txc0, txd0}, {8'h80, 64'hFB555555555555D5});
        @(negedge clk);
        chk("t4_pay", {txc0, txd0}, {8'h00, 64'h0001020304050607});
        @(negedge clk);
        chk("t4_term", {txc0, txd0}, {8'hFF, TERM_W});
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!busy0) done = 1;
        end
        en0 = 1'b0;
        chk("t4_finished", done, 1);
        chk("t4_rx", {rxcnt0, errcnt0}, {32'd3, 32'd0});

        // ---- T5: saturation and clear vs FD ----
        len = 16'd8; num = 16'd0; en1 = 1'b1; n = 0;
        for (int c = 0; c < 3000 && n < 300; c++) begin
            @(negedge clk);
            if (txc1 == 8'hFF && txd1 == TERM_W) n++;
        end
        chk("t5_frames", n, 300);
        chk("t5_txcnt", txcnt1, 8'hFF);
        chk("t5_rxcnt", rxcnt1, 8'hFF);
        chk("t5_errcnt", errcnt1, 8'h00);
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (txc1 == 8'h00) done = 1;
        end
        chk("t5_found_pay", done, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t5_clr_term", {txc1, txd1}, {8'hFF, TERM_W});
        chk("t5_clr_txcnt", txcnt1, 0);
        chk("t5_clr_rxcnt", rxcnt1, 0);
        @(negedge clk);
        en1 = 1'b0;
        chk("t5_rx_after", rxcnt1, 1);

        // ---- T6a: enable dropped mid-payload ----
        rst0_n = 1'b0; @(negedge clk); rst0_n = 1'b1;
        len = 16'd64; num = 16'd0; en0 = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        en0 = 1'b0;
        n = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (txc0 == 8'hFF && txd0 == TERM_W) done = 1;
            else n++;
        end
        chk("t6_term_seen", done, 1);
        chk("t6_words_after_drop", n, 5);
        chk("t6_txcnt", txcnt0, 1);
        repeat (2) @(negedge clk);
        chk("t6_ifg_busy", {busy0, txd0}, {1'b1, IDLE_W});
        @(negedge clk);
        chk("t6_idle", busy0, 0);
        @(negedge clk);
        chk("t6_stay_idle", {busy0, txc0, txd0}, {1'b0, 8'hFF, IDLE_W});

        // ---- T6b: reset mid-frame ----
        en0 = 1'b1; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (txcnt0 == 2 && txc0 == 8'h00) done = 1;
        end
        chk("t6b_midframe", done, 1);
        rst0_n = 1'b0;
        #1;
        chk("t6b_txd", {txc0, txd0}, {8'hFF, IDLE_W});
        chk("t6b_busy", busy0, 0);
        chk("t6b_cnts", {txcnt0, rxcnt0 | errcnt0}, 64'h0);
        en0 = 1'b0;
        @(negedge clk);
        rst0_n = 1'b1;

        // ---- T7: lane 0 in low byte ----
        len = 16'd20; num = 16'd2; en2 = 1'b1;
        @(negedge clk);
        chk("t7_start", {txc2, txd2}, {8'h01, 64'hD5555555555555FB});
        @(negedge clk);
        chk("t7_pay0", {txc2, txd2}, {8'h00, 64'h0706050403020100});
        @(negedge clk);
        chk("t7_pay1", {txc2, txd2}, {8'h00, 64'h0F0E0D0C0B0A0908});
        @(negedge clk);
        chk("t7_term", {txc2, txd2}, {8'hF0, 64'h070707FD13121110});
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (!busy2) done = 1;
        end
        en2 = 1'b0;
        chk("t7_finished", done, 1);
        chk("t7_rx", {rxcnt2, errcnt2}, {32'd2, 32'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
